// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: serial receiver assembling 8 DATA words + 1 CMD word into {B, A, op, crc}.
// Optional on-the-fly CRC-4 check enabled by defining MTM_ALU_RX_CRC_CHECK_EN.
module mtm_alu_deserializer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sin_i,
   output logic        out_valid_o,
   output logic [31:0] out_a_o,
   output logic [31:0] out_b_o,
   output logic [2:0]  out_op_o,
   output logic [3:0]  out_crc_o,
   output logic        err_data_o,
   output logic        err_crc_o,
   output logic        err_op_o
);
   typedef enum logic [1:0] {IDLE, FLAG, BITS, STOP} state_t;
   state_t      state_q, state_d;
   logic        flag_q, flag_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [3:0]  byte_cnt_q, byte_cnt_d;
   logic [63:0] ab_q, ab_d;
   logic        valid_q, valid_d, err_data_q, err_data_d, err_crc_q, err_crc_d, err_op_q, err_op_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic [3:0]  crc_out_q, crc_out_d;
   logic        data_ok, cmd_ok;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
   logic [3:0]  crc_q, crc_d;
   logic        crc_in, crc_fb, crc_feed;
   // CMD word contributes the constant 1 (in place of d[7]) followed by the op bits
   assign crc_in   = flag_q ? (bit_cnt_q == 3'd0) | sin_i : sin_i;
   assign crc_feed = flag_q ? !bit_cnt_q[2] : !byte_cnt_q[3];
   assign crc_fb   = crc_q[3] ^ crc_in;
`endif
   assign data_ok = sin_i && !flag_q && !byte_cnt_q[3];
   assign cmd_ok  = sin_i && flag_q && byte_cnt_q == 4'd8;
   always_comb begin
      state_d    = state_q;
      flag_d     = flag_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      ab_d       = ab_q;
      valid_d    = 1'b0;
      err_data_d = 1'b0;
      err_crc_d  = 1'b0;
      err_op_d   = 1'b0;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      crc_out_d  = crc_out_q;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
      crc_d      = crc_q;
`endif
      case (state_q)
         IDLE: state_d = sin_i ? IDLE : FLAG;
         FLAG: begin
            flag_d    = sin_i;
            bit_cnt_d = 3'd0;
            state_d   = BITS;
         end
         BITS: begin
            shift_d   = {shift_q[6:0], sin_i};
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = bit_cnt_q == 3'd7 ? STOP : BITS;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
            if (crc_feed) crc_d = {crc_q[2:0], 1'b0} ^ {2'b00, crc_fb, crc_fb};
`endif
         end
         default: begin
            state_d = IDLE;
            if (data_ok) begin
               ab_d       = {ab_q[55:0], shift_q};
               byte_cnt_d = byte_cnt_q + 4'd1;
            end else begin
               // every non-DATA outcome ends the packet: complete or abort
               byte_cnt_d = 4'd0;
               valid_d    = 1'b1;
               err_data_d = !cmd_ok;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
               crc_d      = 4'd0;
               err_crc_d  = cmd_ok && crc_q != shift_q[3:0];
`endif
               if (cmd_ok) begin
                  a_d       = ab_q[31:0];
                  b_d       = ab_q[63:32];
                  op_d      = shift_q[6:4];
                  crc_out_d = shift_q[3:0];
                  err_op_d  = shift_q[5];
               end
            end
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         flag_q     <= 1'b0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
         byte_cnt_q <= 4'd0;
         ab_q       <= 64'd0;
         valid_q    <= 1'b0;
         err_data_q <= 1'b0;
         err_crc_q  <= 1'b0;
         err_op_q   <= 1'b0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         op_q       <= 3'd0;
         crc_out_q  <= 4'd0;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
         crc_q      <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         flag_q     <= flag_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         ab_q       <= ab_d;
         valid_q    <= valid_d;
         err_data_q <= err_data_d;
         err_crc_q  <= err_crc_d;
         err_op_q   <= err_op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         crc_out_q  <= crc_out_d;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
         crc_q      <= crc_d;
`endif
      end
   end
   assign out_valid_o = valid_q;
   assign out_a_o     = a_q;
   assign out_b_o     = b_q;
   assign out_op_o    = op_q;
   assign out_crc_o   = crc_out_q;
   assign err_data_o  = err_data_q;
   assign err_crc_o   = err_crc_q;
   assign err_op_o    = err_op_q;
endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed self-checking bench for mtm_alu_deserializer.
module tb_mtm_alu_deserializer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sin = 1'b1;
   logic        out_valid, err_data, err_crc, err_op;
   logic [31:0] out_a, out_b;
   logic [2:0]  out_op;
   logic [3:0]  out_crc;
   int          tests = 0, fails = 0;
   int          vcnt = 0;
   logic [31:0] cap_a, cap_b, prev_a, prev_b;
   logic [2:0]  cap_op;
   logic [3:0]  cap_crc;
   logic        cap_ed, cap_ec, cap_eo;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
   localparam logic CRC_EN = 1'b1;
`else
   localparam logic CRC_EN = 1'b0;
`endif

   mtm_alu_deserializer dut (
      .clk(clk), .rst_n(rst_n), .sin_i(sin), .out_valid_o(out_valid),
      .out_a_o(out_a), .out_b_o(out_b), .out_op_o(out_op), .out_crc_o(out_crc),
      .err_data_o(err_data), .err_crc_o(err_crc), .err_op_o(err_op)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (out_valid === 1'b1) begin
      vcnt++;
      prev_a = cap_a; prev_b = cap_b;
      cap_a = out_a; cap_b = out_b; cap_op = out_op; cap_crc = out_crc;
      cap_ed = err_data; cap_ec = err_crc; cap_eo = err_op;
   end

   // reference CRC by long division of {B,A,1,op} * x^4 by x^4+x+1
   function automatic logic [3:0] crc4(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
      logic [71:0] m;
      m = {b, a, 1'b1, op, 4'b0000};
      for (int i = 71; i >= 4; i--) if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
      return m[3:0];
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk) begin sin = 1'b1; rst_n = 1'b1; end
      #1;
   endtask

   task automatic send_word(input logic f, input logic [7:0] d, input logic stop, input logic rst_stop);
      logic [10:0] w;
      w = {1'b0, f, d, stop};
      for (int i = 10; i >= 0; i--) @(negedge clk) begin
         sin = w[i];
         if (i == 0 && rst_stop) rst_n = 1'b0;
      end
   endtask

   task automatic send_data(input logic [31:0] b, input logic [31:0] a, input int n);
      logic [63:0] v;
      v = {b, a};
      for (int i = 0; i < n; i++) send_word(1'b0, v[63 - 8*i -: 8], 1'b1, 1'b0);
   endtask

   task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op, input logic [3:0] crc);
      send_data(b, a, 8);
      send_word(1'b1, {1'b1, op, crc}, 1'b1, 1'b0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; sin = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      tests++; if ({out_a, out_b} !== 64'd0) begin fails++; $display("FAIL reset_ab got=%h exp=0", {out_a, out_b}); end
      tests++; if ({out_op, out_crc} !== 7'd0) begin fails++; $display("FAIL reset_opcrc got=%h exp=0", {out_op, out_crc}); end
      tests++; if ({err_data, err_crc, err_op} !== 3'd0) begin fails++; $display("FAIL reset_err got=%b exp=000", {err_data, err_crc, err_op}); end
      idle(2);
   endtask

   task automatic test_basic;
      int v0;
      v0 = vcnt;
      send_packet(32'h2, 32'h1, 3'b100, crc4(32'h2, 32'h1, 3'b100));
      idle(3);
      tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL basic_count got=%0d exp=%0d", vcnt - v0, 1); end
      tests++; if (cap_a !== 32'h1 || cap_b !== 32'h2) begin fails++; $display("FAIL basic_ab got=%h/%h exp=1/2", cap_a, cap_b); end
      tests++; if (cap_op !== 3'b100 || cap_crc !== crc4(32'h2, 32'h1, 3'b100)) begin fails++; $display("FAIL basic_opcrc got=%b/%h exp=100/%h", cap_op, cap_crc, crc4(32'h2, 32'h1, 3'b100)); end
      tests++; if ({cap_ed, cap_ec, cap_eo} !== 3'b000) begin fails++; $display("FAIL basic_err got=%b exp=000", {cap_ed, cap_ec, cap_eo}); end
      tests++; if (out_valid !== 1'b0 || err_data !== 1'b0) begin fails++; $display("FAIL basic_pulse got=%b%b exp=00", out_valid, err_data); end
   endtask

   task automatic test_crc_err;
      logic [3:0] bad;
      bad = crc4(32'h2, 32'h1, 3'b100) ^ 4'b0001;
      send_packet(32'h2, 32'h1, 3'b100, bad);
      idle(3);
      tests++; if (cap_ec !== CRC_EN || cap_ed !== 1'b0 || cap_eo !== 1'b0) begin fails++; $display("FAIL crc_err got=%b%b%b exp=0%b0", cap_ed, cap_ec, cap_eo, CRC_EN); end
      tests++; if (cap_crc !== bad) begin fails++; $display("FAIL crc_passthru got=%h exp=%h", cap_crc, bad); end
   endtask

   task automatic test_short_packet;
      int v0;
      v0 = vcnt;
      send_data(32'h11223344, 32'h55667788, 7);
      send_word(1'b1, 8'h2F, 1'b1, 1'b0);
      idle(3);
      tests++; if (vcnt !== v0 + 1 || {cap_ed, cap_ec, cap_eo} !== 3'b100) begin fails++; $display("FAIL short_err got=%0d/%b exp=1/100", vcnt - v0, {cap_ed, cap_ec, cap_eo}); end
      send_packet(32'h1, 32'hFFFF_FFFF, 3'b101, crc4(32'h1, 32'hFFFF_FFFF, 3'b101));
      idle(3);
      tests++; if (cap_a !== 32'hFFFF_FFFF || cap_b !== 32'h1 || cap_op !== 3'b101) begin fails++; $display("FAIL short_recover got=%h/%h/%b exp=ffffffff/1/101", cap_a, cap_b, cap_op); end
      tests++; if ({cap_ed, cap_ec, cap_eo} !== 3'b000) begin fails++; $display("FAIL short_recover_err got=%b exp=000", {cap_ed, cap_ec, cap_eo}); end
   endtask

   task automatic test_stop_err;
      send_data(32'hAABBCCDD, 32'h0, 3);
      send_word(1'b0, 8'hEE, 1'b0, 1'b0);
      @(negedge clk) sin = 1'b1;
      tests++; if (out_valid !== 1'b1 || err_data !== 1'b1) begin fails++; $display("FAIL stop_latency got=%b%b exp=11", out_valid, err_data); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || err_data !== 1'b0) begin fails++; $display("FAIL stop_pulse got=%b%b exp=00", out_valid, err_data); end
      idle(2);
      send_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, crc4(32'h1234_5678, 32'h9ABC_DEF0, 3'b000));
      idle(3);
      tests++; if (cap_a !== 32'h9ABC_DEF0 || cap_b !== 32'h1234_5678 || {cap_ed, cap_ec, cap_eo} !== 3'b000) begin fails++; $display("FAIL stop_recover got=%h/%h/%b", cap_a, cap_b, {cap_ed, cap_ec, cap_eo}); end
   endtask

   task automatic test_bad_op;
      send_packet(32'h7, 32'h3, 3'b010, crc4(32'h7, 32'h3, 3'b010));
      idle(3);
      tests++; if ({cap_ed, cap_ec, cap_eo} !== 3'b001 || cap_op !== 3'b010) begin fails++; $display("FAIL bad_op got=%b op=%b exp=001 op=010", {cap_ed, cap_ec, cap_eo}, cap_op); end
   endtask

   task automatic test_extra_data;
      send_data(32'h1, 32'h2, 8);
      send_word(1'b0, 8'h00, 1'b1, 1'b0);
      idle(3);
      tests++; if ({cap_ed, cap_ec, cap_eo} !== 3'b100) begin fails++; $display("FAIL extra_data got=%b exp=100", {cap_ed, cap_ec, cap_eo}); end
      send_word(1'b1, 8'h40, 1'b1, 1'b0);
      idle(3);
      tests++; if (cap_ed !== 1'b1) begin fails++; $display("FAIL extra_cmd_dropped got=%b exp=1", cap_ed); end
   endtask

   task automatic test_mid_reset;
      int v0;
      v0 = vcnt;
      send_data(32'hDEAD_BEEF, 32'h0, 5);
      @(negedge clk) rst_n = 1'b0;
      idle(2);
      tests++; if (vcnt !== v0 || out_a !== 32'd0 || out_b !== 32'd0) begin fails++; $display("FAIL mid_reset got=%0d/%h/%h exp=0/0/0", vcnt - v0, out_a, out_b); end
      send_packet(32'hCAFE_BABE, 32'h00C0_FFEE, 3'b001, crc4(32'hCAFE_BABE, 32'h00C0_FFEE, 3'b001));
      idle(3);
      tests++; if (vcnt !== v0 + 1 || cap_a !== 32'h00C0_FFEE || cap_b !== 32'hCAFE_BABE) begin fails++; $display("FAIL mid_reset_recover got=%0d/%h/%h", vcnt - v0, cap_a, cap_b); end
      v0 = vcnt;
      send_data(32'h5, 32'h6, 8);
      send_word(1'b1, {1'b0, 3'b100, crc4(32'h5, 32'h6, 3'b100)}, 1'b1, 1'b1);
      idle(3);
      tests++; if (vcnt !== v0 || out_b !== 32'd0) begin fails++; $display("FAIL reset_at_stop got=%0d/%h exp=0/0", vcnt - v0, out_b); end
   endtask

   task automatic test_back_to_back;
      int v0;
      v0 = vcnt;
      send_packet(32'hA, 32'hB, 3'b100, crc4(32'hA, 32'hB, 3'b100));
      send_packet(32'hC, 32'hD, 3'b101, crc4(32'hC, 32'hD, 3'b101));
      idle(3);
      tests++; if (vcnt !== v0 + 2) begin fails++; $display("FAIL b2b_count got=%0d exp=2", vcnt - v0); end
      tests++; if (prev_a !== 32'hB || prev_b !== 32'hA) begin fails++; $display("FAIL b2b_first got=%h/%h exp=b/a", prev_a, prev_b); end
      tests++; if (cap_a !== 32'hD || cap_b !== 32'hC || {cap_ed, cap_ec, cap_eo} !== 3'b000) begin fails++; $display("FAIL b2b_second got=%h/%h/%b exp=d/c/000", cap_a, cap_b, {cap_ed, cap_ec, cap_eo}); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_crc_err;
      test_short_packet;
      test_stop_err;
      test_bad_op;
      test_extra_data;
      test_mid_reset;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
